i2s_adc_capture: RTL and testbench
==================================

Name: i2s_adc_capture

Overview:
- I2S receiver for the ADAU1761 ADC path: codec is bus master (BCLK/LRCLK in), serial data from codec ADC pin.
- Deserialises stereo frames in the clk domain, packs each frame into a 32-bit word and buffers it in an internal FIFO.
- Read side mirrors the xillybus read-stream handshake (rden/empty/data), so it attaches directly to a /dev/xillybus_read_32 port and feeds captured audio to the CPU.

Parameters:
- SAMPLE_WIDTH, 24: bits captured per channel, MSB first; valid range 16..32.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW frames.

Ports:
- clk  in  1  system clock; must run at least 8x i2s_bclk.
- rst_b  in  1  asynchronous active-low reset.
- en  in  1  capture enable (tie to stream open); 0 flushes the FIFO and idles the FSM.
- i2s_bclk  in  1  codec bit clock, asynchronous to clk.
- i2s_lrclk  in  1  codec word clock; 0 = left, 1 = right.
- i2s_sdata  in  1  codec ADC serial data.
- rden  in  1  read strobe; honoured only when empty=0.
- empty  out  1  FIFO empty.
- data  out  32  {left[SW-1:SW-16], right[SW-1:SW-16]}.
- overflow  out  1  sticky; a frame was dropped because the FIFO was full.

Behaviour:
- Sync: bclk, lrclk and sdata each pass through a 2-flop synchroniser (same depth for all three). A third bclk register detects rising edges; lrclk level and sdata are sampled on that detected edge. All capture logic runs on the clk cycle of the edge strobe.
- Reset (rst_b=0): empty=1, data=0, overflow=0, FIFO pointers 0, FSM=HUNT, shift register and bit counter 0.
- FSM, advancing only on bclk-rise strobes unless stated:
  - HUNT: wait until sampled lrclk falls 1->0. -> DELAY.
  - DELAY: one bclk (I2S one-bit delay), clear shift register and count. -> SHIFT.
  - SHIFT: shift sdata in MSB-first and increment count. When count reaches SAMPLE_WIDTH -> HOLD. Any lrclk change while in SHIFT -> DELAY for the next channel; the short word is left-justified and its missing LSBs are 0.
  - HOLD: ignore sdata until lrclk changes -> DELAY.
- Channel close: the current word is latched when lrclk changes, or on entry to HOLD if earlier.
  - Left word: latched into left_hold.
  - Right word: latched, then a frame is pushed, but only if left_hold was captured in the same frame. The first right word after HUNT is never pushed.
- Push: one clk after the right word closes. If the FIFO is full, the frame is dropped and overflow is set. overflow clears only on reset or en=0.
- Read: rden with empty=0 pops; data updates on the next clk edge (non-FWFT, registered). rden with empty=1 is ignored and data holds. A simultaneous push and pop on a full FIFO is not an overflow; the push succeeds.
- Pointers are FIFO_AW+1 bits; full/empty come from the MSB compare and wrap naturally.
- en=0: within 1 clk, FSM=HUNT, pointers reset, empty=1, overflow=0; data holds its last value. en rising restarts from HUNT, so the first frame is always left-aligned.
- Async rst_b mid-word: everything returns to reset values; no partial frame is emitted.

Optional Feature:
- Macro: I2S_ADC_CAPTURE_PEAK_EN.
- Defined: adds ports peak_clr (in, 1) and peak (out, 16).
  - peak holds the max |left[SW-1:SW-16]| over pushed frames; magnitude saturates, so -32768 -> 0x7FFF.
  - peak_clr=1 forces peak to 0 next clk. If a push coincides with the clear, that push's magnitude is loaded instead.
  - Reset value 0.
- Undefined: no peak logic and no extra ports; all other behaviour identical.

Test Plan:
- Basic frame: en=1, one dummy frame, then left=0xABCDEF, right=0x123456 (SW=24) -> empty falls; rden -> data=0xABCD1234 next clk; empty=1 after.
- Alignment: enable mid-right-channel -> the partial frame is discarded; the first popped word is the first complete left/right pair.
- Overflow: FIFO_AW=2, push 5 frames with no reads -> overflow=1 after the 5th; 4 pops return frames 1-4 in order.
- Short word: 16-bit frames with SW=24, left=0x8001 -> data[31:16]=0x8001, LSBs zero-padded.
- Flush: 3 frames queued, en=0 for 1 clk -> empty=1, overflow=0; re-enable -> FSM hunts for the next left start.
- Peak (macro defined): left samples 0x7000, -0x7FFF (0x8001), 0x1000 -> peak=0x7FFF; peak_clr -> 0; then left=-0x8000 -> 0x7FFF.

Source files
------------

// File: rtl/i2s_adc_capture.sv
// I2S ADC-path receiver: deserialises codec-mastered stereo frames into 32-bit words behind a
// read-stream FIFO (rden/empty/data). Optional peak meter enabled by I2S_ADC_CAPTURE_PEAK_EN.
module i2s_adc_capture #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        en,
    input  logic        i2s_bclk,
    input  logic        i2s_lrclk,
    input  logic        i2s_sdata,
    input  logic        rden,
    output logic        empty,
    output logic [31:0] data,
    output logic        overflow
`ifdef I2S_ADC_CAPTURE_PEAK_EN
    ,
    input  logic        peak_clr,
    output logic [15:0] peak
`endif
);

    localparam int SW    = SAMPLE_WIDTH;
    localparam int CW    = 6;
    localparam int IW    = $clog2(SW);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and bclk rising-edge strobe
    // ------------------------------------------------------------------
    logic [2:0] bclk_sync_reg;
    logic [1:0] lr_sync_reg;
    logic [1:0] sd_sync_reg;
    logic       bclk_rise;
    logic       lr_s;
    logic       sd_s;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bclk_sync_reg <= '0;
            lr_sync_reg   <= '0;
            sd_sync_reg   <= '0;
        end else begin
            bclk_sync_reg <= {bclk_sync_reg[1:0], i2s_bclk};
            lr_sync_reg   <= {lr_sync_reg[0], i2s_lrclk};
            sd_sync_reg   <= {sd_sync_reg[0], i2s_sdata};
        end
    end

    assign bclk_rise = bclk_sync_reg[1] & ~bclk_sync_reg[2];
    assign lr_s      = lr_sync_reg[1];
    assign sd_s      = sd_sync_reg[1];

    // ------------------------------------------------------------------
    // Channel FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [SW-1:0]   shift_reg, shift_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            chan_reg, chan_next;
    logic            lr_prev_reg;
    logic            lr_change;
    logic            lr_fall;
    logic            close_word;
    logic [IW-1:0]   bit_idx;

    assign lr_change = bclk_rise & (lr_s != lr_prev_reg);
    assign lr_fall   = bclk_rise & lr_prev_reg & ~lr_s;
    assign bit_idx   = IW'(SW - 1) - IW'(count_reg);

    // The one-bit I2S delay is the bclk on which the lrclk change is seen, so the
    // DELAY state already receives the MSB of the new channel.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        chan_next  = chan_reg;
        close_word = 1'b0;
        if (!en) begin
            state_next = HUNT;
            shift_next = '0;
            count_next = '0;
        end else if (bclk_rise) begin
            case (state_reg)
                HUNT: begin
                    if (lr_fall) begin
                        state_next = DELAY;
                        chan_next  = 1'b0;
                    end
                end
                DELAY: begin
                    if (lr_change) begin
                        chan_next = lr_s;
                    end else begin
                        shift_next         = '0;
                        shift_next[SW - 1] = sd_s;
                        count_next         = CW'(1);
                        state_next         = SHIFT;
                    end
                end
                SHIFT: begin
                    shift_next[bit_idx] = sd_s;
                    count_next          = count_reg + CW'(1);
                    if (lr_change) begin
                        close_word = 1'b1;
                        state_next = DELAY;
                        chan_next  = lr_s;
                    end else if (count_reg == CW'(SW - 1)) begin
                        close_word = 1'b1;
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (lr_change) begin
                        state_next = DELAY;
                        chan_next  = lr_s;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly: left word held until its right partner closes
    // ------------------------------------------------------------------
    logic [15:0] left_hold_reg;
    logic        left_valid_reg;
    logic        push_reg;
    logic [31:0] push_data_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg      <= HUNT;
            shift_reg      <= '0;
            count_reg      <= '0;
            chan_reg       <= 1'b0;
            lr_prev_reg    <= 1'b0;
            left_hold_reg  <= '0;
            left_valid_reg <= 1'b0;
            push_reg       <= 1'b0;
            push_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            chan_reg  <= chan_next;
            push_reg  <= 1'b0;
            if (bclk_rise) begin
                lr_prev_reg <= lr_s;
            end
            if (!en) begin
                left_valid_reg <= 1'b0;
            end else if (close_word) begin
                if (!chan_reg) begin
                    left_hold_reg  <= shift_next[SW-1 -: 16];
                    left_valid_reg <= 1'b1;
                end else begin
                    if (left_valid_reg) begin
                        push_reg      <= 1'b1;
                        push_data_reg <= {left_hold_reg, shift_next[SW-1 -: 16]};
                    end
                    left_valid_reg <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO with registered (non-FWFT) read port
    // ------------------------------------------------------------------
    logic [31:0]      mem [DEPTH];
    logic [FIFO_AW:0] wptr_reg;
    logic [FIFO_AW:0] rptr_reg;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic [31:0]      data_reg;
    logic             overflow_reg;

    assign empty   = (wptr_reg == rptr_reg);
    assign full    = (wptr_reg[FIFO_AW] != rptr_reg[FIFO_AW]) &&
                     (wptr_reg[FIFO_AW-1:0] == rptr_reg[FIFO_AW-1:0]);
    assign pop     = en & rden & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = en & push_reg & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg[FIFO_AW-1:0]] <= push_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
        end else if (!en) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (push_reg && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
                data_reg <= mem[rptr_reg[FIFO_AW-1:0]];
            end
        end
    end

    assign data     = data_reg;
    assign overflow = overflow_reg;

`ifdef I2S_ADC_CAPTURE_PEAK_EN
    // ------------------------------------------------------------------
    // Peak |left| meter over pushed frames
    // ------------------------------------------------------------------
    logic [15:0] left_top;
    logic [15:0] mag;
    logic [15:0] peak_reg;

    assign left_top = push_data_reg[31:16];

    always_comb begin
        mag = left_top;
        if (left_top[15]) begin
            mag = (left_top == 16'h8000) ? 16'h7FFF : (~left_top + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            peak_reg <= '0;
        end else if (peak_clr) begin
            peak_reg <= push_ok ? mag : 16'h0000;
        end else if (push_ok && (mag > peak_reg)) begin
            peak_reg <= mag;
        end
    end

    assign peak = peak_reg;
`endif

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Directed bench for i2s_adc_capture: a behavioural I2S transmitter plays frames with
// standard one-bit delay; popped words are compared with hand-packed expectations.
module tb_i2s_adc_capture;

    localparam int SW = 24;
    localparam int AW = 2;

    logic        clk       = 1'b0;
    logic        rst_b     = 1'b0;
    logic        en        = 1'b0;
    logic        i2s_bclk  = 1'b1;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic        rden      = 1'b0;
    logic        empty;
    logic [31:0] data;
    logic        overflow;
`ifdef I2S_ADC_CAPTURE_PEAK_EN
    logic        peak_clr  = 1'b0;
    logic [15:0] peak;
`endif

    int   n_checks    = 0;
    int   n_fail      = 0;
    logic pending_bit = 1'b0;

    logic [23:0] fl [5] = '{24'h111111, 24'h2A2A2A, 24'h333333, 24'hC4C4C4, 24'h555555};
    logic [23:0] fr [5] = '{24'hA1A1A1, 24'h0B0B0B, 24'hC3C3C3, 24'h1D1D1D, 24'hE5E5E5};

    always #5 clk = ~clk;

    i2s_adc_capture #(
        .SAMPLE_WIDTH(SW),
        .FIFO_AW     (AW)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (en),
        .i2s_bclk (i2s_bclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata),
        .rden     (rden),
        .empty    (empty),
        .data     (data),
        .overflow (overflow)
`ifdef I2S_ADC_CAPTURE_PEAK_EN
        ,
        .peak_clr (peak_clr),
        .peak     (peak)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Outputs change on bclk fall, codec-style; the DUT samples on bclk rise.
    task automatic bclk_cycle(input logic lr, input logic sd);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = sd;
        #40;
        i2s_bclk  = 1'b1;
        #40;
    endtask

    // w is left-justified; slot position 0 carries the previous word's trailing bit.
    task automatic send_word(input logic ch, input logic [31:0] w, input int nbits,
                             input int slot, input int en_at);
        logic b;
        for (int j = 0; j < slot; j++) begin
            if (j == en_at) en = 1'b1;
            if (j == 0)               b = pending_bit;
            else if (j - 1 < nbits)   b = w[31 - (j - 1)];
            else                      b = 1'b0;
            bclk_cycle(ch, b);
        end
        pending_bit = (slot - 1 < nbits) ? w[31 - (slot - 1)] : 1'b0;
    endtask

    task automatic f24(input logic [23:0] l, input logic [23:0] r);
        send_word(1'b0, {l, 8'h00}, 24, 32, -1);
        send_word(1'b1, {r, 8'h00}, 24, 32, -1);
    endtask

    task automatic f16(input logic [15:0] l, input logic [15:0] r);
        send_word(1'b0, {l, 16'h0000}, 16, 16, -1);
        send_word(1'b1, {r, 16'h0000}, 16, 16, -1);
    endtask

    task automatic tail();
        bclk_cycle(1'b0, pending_bit);
        repeat (3) bclk_cycle(1'b0, 1'b0);
        pending_bit = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        @(negedge clk) rden = 1'b1;
        @(negedge clk) rden = 1'b0;
        check(tag, data, exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_data", data, 32'h0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk) rst_b = 1'b1;
        en = 1'b1;

        // Basic frame after one unaligned dummy frame
        f24(24'h111111, 24'h222222);
        f24(24'hABCDEF, 24'h123456);
        tail();
        settle();
        check("basic_not_empty", 32'(empty), 32'd0);
        check("basic_overflow", 32'(overflow), 32'd0);
        pop("basic_data", 32'hABCD1234);
        check("basic_empty_after", 32'(empty), 32'd1);

        // Read strobe on empty FIFO is ignored
        @(negedge clk) rden = 1'b1;
        @(negedge clk) rden = 1'b0;
        check("empty_read_data_hold", data, 32'hABCD1234);
        check("empty_read_still_empty", 32'(empty), 32'd1);

        // Enable rises mid right channel
        @(negedge clk) en = 1'b0;
        send_word(1'b0, {24'h5A5A5A, 8'h00}, 24, 32, -1);
        send_word(1'b1, {24'hA5A5A5, 8'h00}, 24, 32, 10);
        f24(24'h13579B, 24'h2468AC);
        f24(24'hFEDCBA, 24'h0F1E2D);
        tail();
        settle();
        pop("align_first", 32'h13572468);
        pop("align_second", 32'hFEDC0F1E);
        check("align_empty", 32'(empty), 32'd1);

        // 16-bit frames into a 24-bit capture
        restart();
        f16(16'h1111, 16'h2222);
        f16(16'h8001, 16'h7FFE);
        f16(16'h0001, 16'hFFFF);
        tail();
        settle();
        pop("short_neg", 32'h80017FFE);
        pop("short_pos", 32'h0001FFFF);
        check("short_empty", 32'(empty), 32'd1);

        // Overflow with a 4-deep FIFO
        restart();
        f24(24'h111111, 24'h222222);
        for (int i = 0; i < 4; i++) f24(fl[i], fr[i]);
        settle();
        check("ovf_after_4", 32'(overflow), 32'd0);
        f24(fl[4], fr[4]);
        settle();
        check("ovf_after_5", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            pop($sformatf("ovf_pop%0d", i + 1), {fl[i][23:8], fr[i][23:8]});
        end
        check("ovf_drained_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Flush with frames queued, then re-hunt
        f24(24'h010203, 24'h040506);
        f24(24'h070809, 24'h0A0B0C);
        f24(24'h0D0E0F, 24'h101112);
        settle();
        check("flush_queued", 32'(empty), 32'd0);
        @(negedge clk) en = 1'b0;
        @(negedge clk);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_overflow_clr", 32'(overflow), 32'd0);
        check("flush_data_hold", data, {fl[3][23:8], fr[3][23:8]});
        en = 1'b1;
        f24(24'h4B4C4D, 24'h6E6F70);
        settle();
        pop("flush_rehunt", 32'h4B4C6E6F);
        check("flush_rehunt_empty", 32'(empty), 32'd1);
        tail();

`ifdef I2S_ADC_CAPTURE_PEAK_EN
        restart();
        f24(24'h111111, 24'h222222);
        @(negedge clk) peak_clr = 1'b1;
        @(negedge clk) peak_clr = 1'b0;
        check("peak_clr_initial", 32'(peak), 32'h0);
        f24(24'h700000, 24'h000001);
        settle();
        check("peak_pos", 32'(peak), 32'h7000);
        f24(24'h800100, 24'h000002);
        f24(24'h100000, 24'h000003);
        settle();
        check("peak_neg", 32'(peak), 32'h7FFF);
        @(negedge clk) peak_clr = 1'b1;
        @(negedge clk) peak_clr = 1'b0;
        check("peak_clr", 32'(peak), 32'h0);
        f24(24'h800000, 24'h000004);
        settle();
        check("peak_saturate", 32'(peak), 32'h7FFF);
        tail();
`endif

        // Asynchronous reset in the middle of a frame
        restart();
        f24(24'h111111, 24'h222222);
        f24(24'h3C3D3E, 24'h5F6061);
        send_word(1'b0, {24'h777777, 8'h00}, 24, 32, -1);
        settle();
        check("rst_queued", 32'(empty), 32'd0);
        #3 rst_b = 1'b0;
        @(negedge clk);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_data", data, 32'h0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        @(negedge clk) rst_b = 1'b1;
        send_word(1'b1, {24'h999999, 8'h00}, 24, 32, -1);
        f24(24'h2C2D2E, 24'h8A8B8C);
        settle();
        pop("rst_first_frame", 32'h2C2D8A8B);
        check("rst_final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
